apb_bridge_fsm: RTL and testbench

Sequencing state machine of the AHB-to-APB bridge. It sits between the bridge address decoder and the seven APB slaves. It accepts one decoded AHB transfer at a time (the decoder's valid strobe, one-hot slave select and read-data mux) and drives the APB SETUP/ACCESS protocol. It stalls the AHB side through hreadyout until the slave completes, and returns read data and the response.

---
 rtl/apb_bridge_fsm.sv | 139 +++++++++++++
 tb/tb_apb_bridge_fsm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_fsm.sv
// APB sequencing FSM of the AHB-to-APB bridge: IDLE -> [WDATA] -> SETUP -> ACCESS.
// Optional ACCESS timeout with two-cycle ERROR response, enabled by `define APB_TIMEOUT_EN.
module apb_bridge_fsm #(
  parameter int NSLV           = 7,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            pclk,
  input  logic            hresetn,
  input  logic            valid,
  input  logic            hwrite,
  input  logic [AW-1:0]   haddr,
  input  logic [DW-1:0]   hwdata,
  input  logic [NSLV-1:0] psel_dec,
  input  logic [DW-1:0]   prdata_mux,
  input  logic            pready,
  output logic            hreadyout,
  output logic [1:0]      hresp,
  output logic [DW-1:0]   hrdata,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  output logic            pwrite,
  output logic [NSLV-1:0] psel,
  output logic            penable
);

`ifdef APB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, WDATA, SETUP, ACCESS} state_t;
  // TIMEOUT_CYCLES only matters when the timeout is built in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW-1:0]   hrdata_q, hrdata_d;
  logic            pwrite_q, pwrite_d;
  logic [NSLV-1:0] sel_q, sel_d;

  always_ff @(posedge pclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid) begin
          paddr_d  = haddr;
          pwrite_d = hwrite;
          sel_d    = psel_dec;
          // A transfer outside every slave completes at once; only a read clears hrdata.
          if (psel_dec == '0) begin
            if (!hwrite) hrdata_d = '0;
          end else begin
            state_d = hwrite ? WDATA : SETUP;
          end
        end
      end
      WDATA: begin
        pwdata_d = hwdata;
        state_d  = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          if (!pwrite_q) hrdata_d = prdata_mux;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR1: state_d = ERR2;
      ERR2: state_d = IDLE;
`else
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign psel    = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign penable = (state_q == ACCESS);
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign hrdata  = hrdata_q;
`ifdef APB_TIMEOUT_EN
  assign hreadyout = (state_q == IDLE) || (state_q == ERR2);
  assign hresp     = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;
`else
  assign hreadyout = (state_q == IDLE);
  assign hresp     = 2'b00;
`endif

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Self-checking bench for apb_bridge_fsm: directed plan steps plus randomized transfers
// checked cycle by cycle against a transfer-level timing model.
module tb_apb_bridge_fsm;
  localparam int NSLV = 7;

  logic            pclk = 1'b0;
  logic            hresetn;
  logic            valid, hwrite, pready;
  logic [31:0]     haddr, hwdata, prdata_mux;
  logic [NSLV-1:0] psel_dec;
  logic            hreadyout, pwrite, penable;
  logic [1:0]      hresp;
  logic [31:0]     hrdata, paddr, pwdata;
  logic [NSLV-1:0] psel;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hrdata, exp_pwdata;

  apb_bridge_fsm dut (
    .pclk(pclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .psel_dec(psel_dec), .prdata_mux(prdata_mux), .pready(pready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one transfer starting at a negedge of an IDLE cycle and returns at the
  // negedge of the cycle in which hreadyout is high again (ready for back-to-back).
  task automatic do_xfer(input bit wr, input logic [NSLV-1:0] sel, input logic [31:0] addr,
                         input logic [31:0] data, input int waits);
    int s, last;
    bit in_sel, in_acc;
    logic [31:0] rdata;
    rdata    = $urandom;
    valid    = 1'b1; hwrite = wr; haddr = addr; psel_dec = sel;
    pready   = 1'b0; hwdata = $urandom; prdata_mux = $urandom;
    @(posedge pclk);
    if (sel == '0) begin
      @(negedge pclk);
      valid = 1'b0; haddr = $urandom;
      if (!wr) exp_hrdata = 32'h0;
      chk("zs_hready", 32'(hreadyout), 32'd1);
      chk("zs_psel",   32'(psel), 32'd0);
      chk("zs_hrdata", hrdata, exp_hrdata);
      chk("zs_paddr",  paddr, addr);
      $display("xfer zero-select %s addr=%h hrdata=%h", wr ? "WR" : "RD", addr, hrdata);
      return;
    end
    s    = wr ? 2 : 1;          // cycle index of SETUP after the accept edge
    last = s + waits + 2;       // first cycle with hreadyout high again
    if (wr) exp_pwdata = data;
    for (int c = 1; c <= last; c++) begin
      @(negedge pclk);
      in_sel = (c >= s) && (c <= s + waits + 1);
      in_acc = (c > s) && (c <= s + waits + 1);
      if (c == last && !wr) exp_hrdata = rdata;
      chk("psel",    32'(psel), in_sel ? 32'(sel) : 32'd0);
      chk("penable", 32'(penable), 32'(in_acc));
      chk("hready",  32'(hreadyout), 32'(c == last));
      chk("hresp",   32'(hresp), 32'd0);
      chk("hrdata",  hrdata, exp_hrdata);
      if (c >= s) begin
        chk("paddr",  paddr, addr);
        chk("pwrite", 32'(pwrite), 32'(wr));
        chk("pwdata", pwdata, exp_pwdata);
      end
      valid      = 1'b0; haddr = $urandom; psel_dec = $urandom; hwrite = $urandom;
      hwdata     = (c == 1) ? data : $urandom;
      pready     = (c == s + waits + 1);
      prdata_mux = pready ? rdata : $urandom;
    end
    $display("xfer %s sel=%b addr=%h data=%h waits=%0d hrdata=%h",
             wr ? "WR" : "RD", sel, addr, wr ? data : rdata, waits, hrdata);
  endtask

  initial begin
    logic [NSLV-1:0] one;
    one = 7'd1;
    hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; pready = 1'b0;
    haddr = '0; hwdata = '0; prdata_mux = '0; psel_dec = '0;
    exp_hrdata = '0; exp_pwdata = '0;

    // Reset state
    @(negedge pclk); @(negedge pclk);
    chk("rst_hready",  32'(hreadyout), 32'd1);
    chk("rst_hresp",   32'(hresp), 32'd0);
    chk("rst_psel",    32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_hrdata",  hrdata, 32'd0);
    chk("rst_paddr",   paddr, 32'd0);
    chk("rst_pwdata",  pwdata, 32'd0);
    chk("rst_pwrite",  32'(pwrite), 32'd0);
    hresetn = 1'b1;
    @(negedge pclk);

    // Directed plan: read slave 2, write slave 0, read with 3 wait cycles
    do_xfer(1'b0, 7'b0000100, 32'h4000_0C10, 32'h0, 0);
    do_xfer(1'b1, 7'b0000001, 32'h4000_0404, 32'h1234_5678, 0);
    do_xfer(1'b0, 7'b0001000, 32'h4000_0820, 32'h0, 3);
    // Back-to-back write slave 6 then read slave 1, no gap cycle
    do_xfer(1'b1, 7'b1000000, 32'h4000_1800, 32'hCAFE_F00D, 0);
    do_xfer(1'b0, 7'b0000010, 32'h4000_0000, 32'h0, 0);
    // Zero-select write keeps hrdata, zero-select read clears it
    do_xfer(1'b1, 7'b0000000, 32'h5000_0000, 32'h1111_2222, 0);
    do_xfer(1'b0, 7'b0000000, 32'h5000_0004, 32'h0, 0);

    // Asynchronous reset during ACCESS
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h4000_0C00; psel_dec = 7'b0001000; pready = 1'b0;
    @(posedge pclk); @(negedge pclk);
    valid = 1'b0;
    @(negedge pclk);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    #2 hresetn = 1'b0;
    #1;
    chk("arst_psel",    32'(psel), 32'd0);
    chk("arst_penable", 32'(penable), 32'd0);
    chk("arst_hready",  32'(hreadyout), 32'd1);
    chk("arst_paddr",   paddr, 32'd0);
    $display("async reset during ACCESS psel=%b penable=%b hready=%b", psel, penable, hreadyout);
    exp_hrdata = '0; exp_pwdata = '0;
    @(negedge pclk);
    hresetn = 1'b1;
    do_xfer(1'b0, 7'b0000100, 32'h4000_0C14, 32'h0, 1);

`ifdef APB_TIMEOUT_EN
    // Timeout: pready never rises; 16 ACCESS cycles then ERR1/ERR2
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h4000_1400; psel_dec = 7'b0100000; pready = 1'b0;
    @(posedge pclk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge pclk);
      valid = 1'b0;
      chk("to_psel",    32'(psel), (c >= 1 && c <= 17) ? 32'h20 : 32'd0);
      chk("to_penable", 32'(penable), 32'(c >= 2 && c <= 17));
      chk("to_hresp",   32'(hresp), (c == 18 || c == 19) ? 32'd1 : 32'd0);
      chk("to_hready",  32'(hreadyout), 32'(c >= 19));
      chk("to_hrdata",  hrdata, exp_hrdata);
    end
    $display("timeout transfer hresp=%b hready=%b", hresp, hreadyout);
`endif

    // Randomized transfers with optional idle gaps
    for (int i = 0; i < 40; i++) begin
      bit wr;
      int gap;
      logic [NSLV-1:0] sel;
      wr  = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 9) == 0) ? '0 : (one << $urandom_range(0, NSLV - 1));
      do_xfer(wr, sel, $urandom, $urandom, $urandom_range(0, 3));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge pclk);
        chk("idle_hready", 32'(hreadyout), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
